// File: rtl/scan_sequencer_4bit.sv
// Scan sequencer for a 4-to-16 decoder: steps the select code 0..LAST.
// Each code gets a blanking gap (en low) and then a dwell (en high).
module scan_sequencer_4bit #(
  parameter int unsigned DWELL = 4,
  parameter int unsigned BLANK = 1,
  parameter int unsigned LAST  = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic stop,
  input  logic oneshot,
  output logic A,
  output logic B,
  output logic C,
  output logic D,
  output logic en,
  output logic busy,
  output logic frame_done
);

  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_DRIVE} state_t;

  localparam logic [15:0] DWELL_M1 = 16'(DWELL - 1);
  localparam logic [15:0] BLANK_M1 = (BLANK == 0) ? 16'd0 : 16'(BLANK - 1);
  localparam logic [3:0]  LAST_C   = 4'(LAST);
  localparam logic        NO_BLANK = (BLANK == 0);
  // A code starts with its blanking gap, or goes straight to DRIVE when BLANK=0
  localparam state_t      CODE_ENTRY = NO_BLANK ? S_DRIVE : S_BLANK;

  state_t      state_q;
  logic [15:0] cnt_q;
  logic [3:0]  code_q;
  logic        mode_q, stop_pend_q, en_q, busy_q, fd_q;
  logic        end_req;

  assign end_req = stop | stop_pend_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      code_q      <= '0;
      mode_q      <= 1'b0;
      stop_pend_q <= 1'b0;
      en_q        <= 1'b0;
      busy_q      <= 1'b0;
      fd_q        <= 1'b0;
    end else begin
      fd_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start && !stop) begin
            mode_q  <= oneshot;
            code_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= CODE_ENTRY;
            en_q    <= NO_BLANK;
          end
        end
        S_BLANK: begin
          if (end_req) begin
            state_q     <= S_IDLE;
            code_q      <= '0;
            cnt_q       <= '0;
            en_q        <= 1'b0;
            busy_q      <= 1'b0;
            stop_pend_q <= 1'b0;
          end else if (cnt_q == BLANK_M1) begin
            cnt_q   <= '0;
            state_q <= S_DRIVE;
            en_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        S_DRIVE: begin
          if (stop) stop_pend_q <= 1'b1;
          // A driven code always completes its dwell; stop only acts at the boundary
          if (cnt_q == DWELL_M1) begin
            cnt_q <= '0;
            if (code_q == LAST_C) fd_q <= 1'b1;
            if ((code_q == LAST_C && mode_q) || end_req) begin
              state_q     <= S_IDLE;
              code_q      <= '0;
              en_q        <= 1'b0;
              busy_q      <= 1'b0;
              stop_pend_q <= 1'b0;
            end else begin
              code_q  <= (code_q == LAST_C) ? 4'd0 : code_q + 4'd1;
              state_q <= CODE_ENTRY;
              en_q    <= NO_BLANK;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign {A, B, C, D} = code_q;
  assign en           = en_q;
  assign busy         = busy_q;
  assign frame_done   = fd_q;

endmodule

// File: tb/tb_scan_sequencer_4bit.sv
// Directed bench: one instance with DWELL=4/BLANK=2/LAST=15 and one with
// DWELL=1/BLANK=0/LAST=3. The outputs are compared as {ABCD,en,busy,frame_done}.
module tb_scan_sequencer_4bit;

  logic clk, rst_n;
  logic start0, stop0, oneshot0, start1, stop1, oneshot1;
  logic A0, B0, C0, D0, en0, busy0, fd0;
  logic A1, B1, C1, D1, en1, busy1, fd1;
  logic [6:0] a0, a1;
  int nvec, nerr;

  typedef struct {
    logic       st, sp, os;
    logic [6:0] exp;
  } vec_t;
  vec_t tbl[$];

  scan_sequencer_4bit #(.DWELL(4), .BLANK(2), .LAST(15)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .stop(stop0), .oneshot(oneshot0),
    .A(A0), .B(B0), .C(C0), .D(D0), .en(en0), .busy(busy0), .frame_done(fd0));

  scan_sequencer_4bit #(.DWELL(1), .BLANK(0), .LAST(3)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .stop(stop1), .oneshot(oneshot1),
    .A(A1), .B(B1), .C(C1), .D(D1), .en(en1), .busy(busy1), .frame_done(fd1));

  assign a0 = {A0, B0, C0, D0, en0, busy0, fd0};
  assign a1 = {A1, B1, C1, D1, en1, busy1, fd1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] ev(int c, logic e, logic b, logic f);
    return {4'(c), e, b, f};
  endfunction

  // One-pass frame, t = edges after the start edge
  function automatic logic [6:0] exp_os(int t);
    if (t < 96)  return ev(t / 6, (t % 6) >= 2, 1'b1, 1'b0);
    if (t == 96) return ev(0, 1'b0, 1'b0, 1'b1);
    return ev(0, 1'b0, 1'b0, 1'b0);
  endfunction

  // Continuous run; stop lands in the 2nd DRIVE cycle of code 7 in frame 4
  function automatic logic [6:0] exp_ct(int t);
    if (t >= 336) return ev(0, 1'b0, 1'b0, 1'b0);
    return ev((t / 6) % 16, (t % 6) >= 2, 1'b1, (t > 0) && (t % 96 == 0));
  endfunction

  task automatic cmp(input string nm, input logic [6:0] act, input logic [6:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got abcd/en/busy/fd=%b/%b/%b/%b want %b/%b/%b/%b",
               nm, act[6:3], act[2], act[1], act[0], exp[6:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic add(input logic st, input logic sp, input logic os, input logic [6:0] e);
    vec_t v;
    v.st = st; v.sp = sp; v.os = os; v.exp = e;
    tbl.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    nvec = 0; nerr = 0;
    rst_n = 1'b0;
    {start0, stop0, oneshot0, start1, stop1, oneshot1} = '0;

    // Table: idle hold, start+stop refused, one-pass start, codes 0..2, stop in BLANK of code 3
    add(0, 0, 0, ev(0, 0, 0, 0));
    add(1, 1, 0, ev(0, 0, 0, 0));
    add(1, 0, 1, ev(0, 0, 1, 0));
    add(0, 0, 0, ev(0, 0, 1, 0));
    for (int c = 0; c < 3; c++) begin
      for (int k = 0; k < 4; k++) add(0, 0, 0, ev(c, 1, 1, 0));
      if (c < 2) for (int k = 0; k < 2; k++) add(0, 0, 0, ev(c + 1, 0, 1, 0));
    end
    add(0, 0, 0, ev(3, 0, 1, 0));
    add(0, 1, 0, ev(0, 0, 0, 0));
    add(0, 0, 0, ev(0, 0, 0, 0));

    #7;
    cmp("reset_u0", a0, ev(0, 0, 0, 0));
    cmp("reset_u1", a1, ev(0, 0, 0, 0));
    tick();
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      start0 = tbl[i].st; stop0 = tbl[i].sp; oneshot0 = tbl[i].os;
      tick();
      cmp($sformatf("tbl[%0d]", i), a0, tbl[i].exp);
    end
    {start0, stop0, oneshot0} = '0;

    // Full one-pass frame
    start0 = 1'b1; oneshot0 = 1'b1;
    tick();
    start0 = 1'b0; oneshot0 = 1'b0;
    cmp("os_t0", a0, ev(0, 0, 1, 0));
    for (int t = 1; t <= 100; t++) begin
      tick();
      cmp($sformatf("os_t%0d", t), a0, exp_os(t));
    end

    // Continuous: three frames, then stop mid-dwell of code 7
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    for (int t = 0; t <= 340; t++) begin
      if (t > 0) tick();
      cmp($sformatf("ct_t%0d", t), a0, exp_ct(t));
      if (t == 333) stop0 = 1'b1;
    end
    stop0 = 1'b0;

    // Asynchronous reset in the middle of DRIVE of code 5
    start0 = 1'b1; oneshot0 = 1'b1;
    tick();
    start0 = 1'b0; oneshot0 = 1'b0;
    for (int t = 1; t <= 32; t++) tick();
    cmp("pre_rst", a0, ev(5, 1, 1, 0));
    #3 rst_n = 1'b0;
    #1 cmp("async_rst", a0, ev(0, 0, 0, 0));
    tick();
    rst_n = 1'b1;
    for (int t = 0; t < 5; t++) begin
      tick();
      cmp($sformatf("post_rst%0d", t), a0, ev(0, 0, 0, 0));
    end

    // No blanking, single-cycle dwell, LAST=3, continuous
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int t = 0; t <= 15; t++) begin
      if (t > 0) tick();
      cmp($sformatf("nb_t%0d", t), a1, ev(t % 4, 1, 1, (t > 0) && (t % 4 == 0)));
    end
    stop1 = 1'b1;
    tick();
    cmp("nb_stop", a1, ev(0, 0, 0, 1));
    stop1 = 1'b0;
    tick();
    cmp("nb_idle", a1, ev(0, 0, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
